// File: rtl/bus_arbiter_if.sv
// Handshake bundle between the two requesting masters, the arbiter and the single slave.
// The arbiter connects through the slave modport; the bench drives through the master modport.
interface bus_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic              HTRANS_1;
  logic              HTRANS_2;
  logic [ADDR_W-1:0] HADDR_1;
  logic [ADDR_W-1:0] HADDR_2;
  logic              HWRITE_1;
  logic              HWRITE_2;
  logic [DATA_W-1:0] HWDATA_1;
  logic [DATA_W-1:0] HWDATA_2;

  logic [ADDR_W-1:0] PADDR;
  logic              HWRITE;
  logic [DATA_W-1:0] PDATA;
  logic              PSEL;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;

  logic [DATA_W-1:0] HRDATA_1;
  logic [DATA_W-1:0] HRDATA_2;
  logic              HREADY_1;
  logic              HREADY_2;
  logic              stall_1;
  logic              stall_2;
  logic              bus_err;

  modport slave (
    input  HTRANS_1, HTRANS_2, HADDR_1, HADDR_2, HWRITE_1, HWRITE_2, HWDATA_1, HWDATA_2,
    input  PREADY, PRDATA,
    output PADDR, HWRITE, PDATA, PSEL,
    output HRDATA_1, HRDATA_2, HREADY_1, HREADY_2, stall_1, stall_2, bus_err
  );

  modport master (
    output HTRANS_1, HTRANS_2, HADDR_1, HADDR_2, HWRITE_1, HWRITE_2, HWDATA_1, HWDATA_2,
    output PREADY, PRDATA,
    input  PADDR, HWRITE, PDATA, PSEL,
    input  HRDATA_1, HRDATA_2, HREADY_1, HREADY_2, stall_1, stall_2, bus_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master, single-slave transfer arbiter with registered slave request and per-transfer timeout.
// Define ARB_ROUND_ROBIN_EN to break ties toward the master not granted last (default: master 2 wins).
module bus_arbiter #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 15
) (
  input logic          CLK,
  input logic          reset,
  bus_arbiter_if.slave bus
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntMax = '1;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;
  typedef enum logic [0:0] {Mst1 = 1'b0, Mst2 = 1'b1} mst_e;

  state_e            state_q;
  mst_e              owner_q;
  logic [CntW-1:0]   wait_cnt_q;
  logic [ADDR_W-1:0] paddr_q;
  logic              hwrite_q;
  logic [DATA_W-1:0] pdata_q;
  logic              psel_q;
  logic [DATA_W-1:0] hrdata_1_q;
  logic [DATA_W-1:0] hrdata_2_q;
  logic              hready_1_q;
  logic              hready_2_q;
  logic              bus_err_q;

`ifdef ARB_ROUND_ROBIN_EN
  mst_e              last_grant_q;
`endif

  logic              req_any;
  mst_e              grant;
  logic [CntW:0]     wait_cnt_inc;
  logic [CntW-1:0]   wait_cnt_sat;
  logic              timeout_hit;

  always_comb begin
    req_any = bus.HTRANS_1 | bus.HTRANS_2;
    grant   = bus.HTRANS_2 ? Mst2 : Mst1;
`ifdef ARB_ROUND_ROBIN_EN
    if (bus.HTRANS_1 && bus.HTRANS_2) begin
      grant = (last_grant_q == Mst2) ? Mst1 : Mst2;
    end
`endif
  end

  // Abort on the edge where the wait count would reach TIMEOUT; a zero TIMEOUT never matches.
  always_comb begin
    wait_cnt_inc = {1'b0, wait_cnt_q} + {{CntW{1'b0}}, 1'b1};
    wait_cnt_sat = (wait_cnt_q == CntMax) ? wait_cnt_q : wait_cnt_inc[CntW-1:0];
    timeout_hit  = (TIMEOUT != 0) && (wait_cnt_inc == (CntW + 1)'(TIMEOUT));
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= Mst1;
      wait_cnt_q   <= '0;
      paddr_q      <= '0;
      hwrite_q     <= 1'b0;
      pdata_q      <= '0;
      psel_q       <= 1'b0;
      hrdata_1_q   <= '0;
      hrdata_2_q   <= '0;
      hready_1_q   <= 1'b0;
      hready_2_q   <= 1'b0;
      bus_err_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= Mst2;
`endif
    end else begin
      hready_1_q <= 1'b0;
      hready_2_q <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_any) begin
            state_q    <= StBusy;
            psel_q     <= 1'b1;
            owner_q    <= grant;
            wait_cnt_q <= '0;
            if (grant == Mst2) begin
              paddr_q  <= bus.HADDR_2;
              hwrite_q <= bus.HWRITE_2;
              pdata_q  <= bus.HWDATA_2;
            end else begin
              paddr_q  <= bus.HADDR_1;
              hwrite_q <= bus.HWRITE_1;
              pdata_q  <= bus.HWDATA_1;
            end
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= grant;
`endif
          end else begin
            psel_q <= 1'b0;
          end
        end
        StBusy: begin
          if (bus.PREADY) begin
            state_q <= StIdle;
            psel_q  <= 1'b0;
            if (owner_q == Mst1) begin
              hready_1_q <= 1'b1;
              if (!hwrite_q) hrdata_1_q <= bus.PRDATA;
            end else begin
              hready_2_q <= 1'b1;
              if (!hwrite_q) hrdata_2_q <= bus.PRDATA;
            end
          end else if (timeout_hit) begin
            state_q    <= StIdle;
            psel_q     <= 1'b0;
            bus_err_q  <= 1'b1;
            wait_cnt_q <= wait_cnt_sat;
            if (owner_q == Mst1) begin
              hready_1_q <= 1'b1;
              hrdata_1_q <= '0;
            end else begin
              hready_2_q <= 1'b1;
              hrdata_2_q <= '0;
            end
          end else begin
            wait_cnt_q <= wait_cnt_sat;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.PADDR    = paddr_q;
  assign bus.HWRITE   = hwrite_q;
  assign bus.PDATA    = pdata_q;
  assign bus.PSEL     = psel_q;
  assign bus.HRDATA_1 = hrdata_1_q;
  assign bus.HRDATA_2 = hrdata_2_q;
  assign bus.HREADY_1 = hready_1_q;
  assign bus.HREADY_2 = hready_2_q;
  assign bus.bus_err  = bus_err_q;
  assign bus.stall_1  = bus.HTRANS_1 & ~hready_1_q;
  assign bus.stall_2  = bus.HTRANS_2 & ~hready_2_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized two-master traffic against an address-driven slave model; a scoreboard predicts
// grant order, completion cycle, read data and bus_err from the arbitration and timeout rules.
module tb_bus_arbiter;

  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned TIMEOUT = 4;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  always #5 CLK = ~CLK;

  bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK  (CLK),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [63:0] addr;
    logic        wr;
    logic [63:0] wdata;
    int unsigned waits;
    logic        err;
    logic [63:0] rdata;
  } req_t;

  typedef struct {
    int unsigned owner;
    int unsigned due;
  } cpl_t;

  req_t        exp1_q[$];
  req_t        exp2_q[$];
  cpl_t        cpl_q[$];
  logic [63:0] model_hr1 = '0;
  logic [63:0] model_hr2 = '0;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned cyc = 0;
  int unsigned last_grant = 2;
  logic        pend1 = 1'b0;
  logic        pend2 = 1'b0;
  logic [1:0]  req_edge = 2'b00;
  logic        rst_edge = 1'b1;

  // The slave's wait count and read data are pure functions of the address.
  function automatic logic [63:0] slave_data(input logic [63:0] a);
    return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
  endfunction

  function automatic int unsigned waits_of(input logic [63:0] a);
    return int'(a[2:0]);
  endfunction

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    a      = {$urandom, $urandom};
    a[2:0] = 3'($urandom_range(0, 5));
    return a;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic issue(input int unsigned m, input logic [63:0] addr, input logic wr);
    req_t r;
    r.addr  = addr;
    r.wr    = wr;
    r.wdata = {$urandom, $urandom};
    r.waits = waits_of(addr);
    r.err   = (r.waits >= TIMEOUT);
    if (m == 1) begin
      r.rdata = r.err ? 64'h0 : (!wr ? slave_data(addr) : model_hr1);
      model_hr1 = r.rdata;
      bus.HTRANS_1 = 1'b1; bus.HADDR_1 = addr; bus.HWRITE_1 = wr; bus.HWDATA_1 = r.wdata;
      exp1_q.push_back(r);
      pend1 = 1'b1;
    end else begin
      r.rdata = r.err ? 64'h0 : (!wr ? slave_data(addr) : model_hr2);
      model_hr2 = r.rdata;
      bus.HTRANS_2 = 1'b1; bus.HADDR_2 = addr; bus.HWRITE_2 = wr; bus.HWDATA_2 = r.wdata;
      exp2_q.push_back(r);
      pend2 = 1'b1;
    end
  endtask

  // One cycle of master activity: release on completion, optionally issue fresh requests.
  task automatic step(input bit rand_new);
    @(negedge CLK);
    #1;
    if (bus.HREADY_1) begin pend1 = 1'b0; bus.HTRANS_1 = 1'b0; end
    if (bus.HREADY_2) begin pend2 = 1'b0; bus.HTRANS_2 = 1'b0; end
    if (rand_new) begin
      if (!pend1 && $urandom_range(0, 2) != 0) issue(1, rand_addr(), 1'($urandom_range(0, 1)));
      if (!pend2 && $urandom_range(0, 2) != 0) issue(2, rand_addr(), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned n = 0;
    while ((pend1 || pend2) && n < budget) begin
      step(1'b0);
      n++;
    end
    check("drain within budget", {63'h0, pend1 | pend2}, 64'h0);
    if (pend1 || pend2) begin
      pend1 = 1'b0; pend2 = 1'b0; bus.HTRANS_1 = 1'b0; bus.HTRANS_2 = 1'b0;
    end
  endtask

  // Slave model: PREADY comes on the (waits+1)-th PSEL cycle; random PREADY while idle.
  initial begin : slave
    int unsigned busy_cnt = 0;
    bus.PREADY = 1'b0;
    bus.PRDATA = '0;
    forever begin
      @(negedge CLK);
      #1;
      if (bus.PSEL) begin
        if (busy_cnt == waits_of(bus.PADDR)) begin
          bus.PREADY = 1'b1;
          bus.PRDATA = slave_data(bus.PADDR);
        end else begin
          bus.PREADY = 1'b0;
          bus.PRDATA = {$urandom, $urandom};
        end
        busy_cnt++;
      end else begin
        busy_cnt   = 0;
        bus.PREADY = 1'($urandom_range(0, 1));
        bus.PRDATA = {$urandom, $urandom};
      end
    end
  end

  always @(posedge CLK) begin
    cyc      <= cyc + 1;
    req_edge <= {bus.HTRANS_2, bus.HTRANS_1};
    rst_edge <= reset;
  end

  always @(negedge CLK) begin : monitor
    req_t        r;
    cpl_t        c;
    logic        exp_h1;
    logic        exp_h2;
    int unsigned win;
    logic        psel_prev;
    logic [63:0] paddr_prev;
    if (!rst_edge) begin
      exp_h1 = 1'b0;
      exp_h2 = 1'b0;
      if (cpl_q.size() != 0 && cpl_q[0].due == cyc) begin
        if (cpl_q[0].owner == 1) exp_h1 = 1'b1;
        else exp_h2 = 1'b1;
      end
      check("HREADY_1", {63'h0, bus.HREADY_1}, {63'h0, exp_h1});
      check("HREADY_2", {63'h0, bus.HREADY_2}, {63'h0, exp_h2});
      check("stall_1", {63'h0, bus.stall_1}, {63'h0, bus.HTRANS_1 & ~exp_h1});
      check("stall_2", {63'h0, bus.stall_2}, {63'h0, bus.HTRANS_2 & ~exp_h2});
      if (exp_h1 || exp_h2) begin
        c = cpl_q.pop_front();
        if (c.owner == 1) begin
          r = exp1_q.pop_front();
          check("HRDATA_1", bus.HRDATA_1, r.rdata);
        end else begin
          r = exp2_q.pop_front();
          check("HRDATA_2", bus.HRDATA_2, r.rdata);
        end
        check("bus_err on completion", {63'h0, bus.bus_err}, {63'h0, r.err});
      end else begin
        check("bus_err quiet", {63'h0, bus.bus_err}, 64'h0);
      end

      if (bus.PSEL && !psel_prev) begin
        win = 0;
        if (req_edge == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
          win = (last_grant == 2) ? 1 : 2;
`else
          win = 2;
`endif
        end else if (req_edge == 2'b10) win = 2;
        else if (req_edge == 2'b01) win = 1;
        check("grant backed by request", {62'h0, req_edge != 2'b00}, 64'h1);
        if (win != 0 && ((win == 1) ? exp1_q.size() : exp2_q.size()) != 0) begin
          r = (win == 1) ? exp1_q[0] : exp2_q[0];
          check("PADDR at grant", bus.PADDR, r.addr);
          check("HWRITE at grant", {63'h0, bus.HWRITE}, {63'h0, r.wr});
          check("PDATA at grant", bus.PDATA, r.wdata);
          last_grant = win;
          c.owner = win;
          c.due   = cyc + ((r.waits < TIMEOUT) ? r.waits + 1 : TIMEOUT);
          cpl_q.push_back(c);
        end
      end else if (bus.PSEL && psel_prev) begin
        check("PADDR held while busy", bus.PADDR, paddr_prev);
      end
    end
    psel_prev  = bus.PSEL;
    paddr_prev = bus.PADDR;
  end

  task automatic check_all_zero(input string tag);
    check({tag, " PSEL"}, {63'h0, bus.PSEL}, 64'h0);
    check({tag, " HWRITE"}, {63'h0, bus.HWRITE}, 64'h0);
    check({tag, " PADDR"}, bus.PADDR, 64'h0);
    check({tag, " PDATA"}, bus.PDATA, 64'h0);
    check({tag, " HRDATA_1"}, bus.HRDATA_1, 64'h0);
    check({tag, " HRDATA_2"}, bus.HRDATA_2, 64'h0);
    check({tag, " HREADY_1"}, {63'h0, bus.HREADY_1}, 64'h0);
    check({tag, " HREADY_2"}, {63'h0, bus.HREADY_2}, 64'h0);
    check({tag, " bus_err"}, {63'h0, bus.bus_err}, 64'h0);
  endtask

  initial begin : driver
    int unsigned prev_done;
    bus.HTRANS_1 = 1'b0; bus.HADDR_1 = '0; bus.HWRITE_1 = 1'b0; bus.HWDATA_1 = '0;
    bus.HTRANS_2 = 1'b0; bus.HADDR_2 = '0; bus.HWRITE_2 = 1'b0; bus.HWDATA_2 = '0;
    reset = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_all_zero("reset");
    #1 reset = 1'b0;

    // Single read, simultaneous requests, wait states, then timeout followed by a normal read.
    issue(1, 64'h1000, 1'b0);
    drain(20);
    issue(1, 64'h0, 1'b0);
    issue(2, 64'h80, 1'b1);
    drain(20);
    issue(1, 64'h1003, 1'b0);
    drain(20);
    issue(2, 64'h2004, 1'b0);
    drain(20);
    issue(2, 64'h2000, 1'b0);
    drain(20);

    // Back-to-back M1 reads: request re-raised in every completion cycle.
    prev_done = 0;
    for (int i = 0; i < 4; i++) begin
      issue(1, 64'h5000 + 64'(i * 8), 1'b0);
      drain(20);
      if (i > 0) check("back-to-back spacing", 64'(cyc - prev_done), 64'd2);
      prev_done = cyc;
    end

    repeat (3000) step(1'b1);
    drain(100);

    // Reset in the middle of a waiting transfer drops it silently.
    issue(1, 64'h3003, 1'b0);
    step(1'b0);
    step(1'b0);
    reset = 1'b1;
    bus.HTRANS_1 = 1'b0;
    pend1 = 1'b0;
    exp1_q.delete();
    exp2_q.delete();
    cpl_q.delete();
    model_hr1 = '0;
    model_hr2 = '0;
    last_grant = 2;
    @(negedge CLK);
    check_all_zero("mid-busy reset");
    #1 reset = 1'b0;
    repeat (4) step(1'b0);
    issue(1, 64'h4000, 1'b0);
    prev_done = cyc;
    drain(20);
    check("post-reset latency", 64'(cyc - prev_done), 64'd2);
    repeat (3) step(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, single-slave transfer arbiter between the CPU pipeline and the memory-side bus. The fetch stage is master 1 and the memory-access stage is master 2. The block latches one winner's request and presents it to the slave as a registered transfer. It returns read data and a one-cycle completion pulse to the owning master, and drives per-master stall. A per-transfer timeout aborts transfers the slave never completes.

## Interface
Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width
- TIMEOUT, 15, number of consecutive wait cycles before abort; 0 disables the timeout

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- HTRANS_1 / HTRANS_2  in  1  request from master 1 (fetch) / master 2 (memory access)
- HADDR_1 / HADDR_2  in  ADDR_W  request address
- HWRITE_1 / HWRITE_2  in  1  1 = write, 0 = read
- HWDATA_1 / HWDATA_2  in  DATA_W  write data
- PADDR  out  ADDR_W  slave address (registered)
- HWRITE  out  1  slave write strobe (registered)
- PDATA  out  DATA_W  slave write data (registered)
- PSEL  out  1  slave transfer valid (registered)
- PREADY  in  1  slave completes the current transfer this cycle
- PRDATA  in  DATA_W  slave read data, valid when PREADY is high
- HRDATA_1 / HRDATA_2  out  DATA_W  read data returned to the master (registered)
- HREADY_1 / HREADY_2  out  1  one-cycle completion pulse
- stall_1 / stall_2  out  1  stall_x = HTRANS_x & ~HREADY_x (combinational)
- bus_err  out  1  pulses together with HREADY_x when the transfer was aborted by timeout

## Operation
- The FSM has two states, IDLE and BUSY.
- **IDLE:**
  - If any HTRANS_x is high, pick a winner.
  - At the edge, latch the winner's HADDR/HWRITE/HWDATA into PADDR/HWRITE/PDATA, set PSEL=1, record the owner and clear the wait counter.
  - Go to BUSY.
  - If no HTRANS_x is high, stay in IDLE with PSEL=0.
- **BUSY:**
  - PSEL, PADDR, HWRITE and PDATA are held constant.
  - PREADY high: at the edge, PSEL<=0 and HREADY_owner<=1.
    - For a read, HRDATA_owner<=PRDATA. For a write, HRDATA_owner is unchanged.
    - Go to IDLE.
  - PREADY low: the wait counter increments.
    - When TIMEOUT≠0 and the counter reaches TIMEOUT, abort at that edge: PSEL<=0, HREADY_owner<=1, bus_err<=1, HRDATA_owner<=0.
    - Go to IDLE.
- Every HREADY_x and bus_err is high for exactly one cycle.
- **Master rule:** hold HTRANS/HADDR/HWRITE/HWDATA stable until HREADY_x is seen. HTRANS_x still high in the HREADY_x cycle counts as a new request.
- **Arbitration (default):** fixed priority, master 2 over master 1.
- **Only one master requests:** that master always wins.
- **Non-owner requests arriving during BUSY:** they wait. The waiting master keeps stall high.
- **Reset (any cycle, including mid-BUSY):**
  - State returns to IDLE and the in-flight transfer is dropped; no HREADY pulse is issued for it.
  - PSEL, HWRITE, HREADY_1, HREADY_2 and bus_err are 0.
  - PADDR, PDATA, HRDATA_1 and HRDATA_2 are 0.
  - The wait counter is 0 and the last-grant register holds master 2.
- Widths are fixed. The wait counter is $clog2(TIMEOUT+1) bits and saturates; it never wraps.

## Timing
- Request in cycle 0 (IDLE) → PSEL high in cycle 1.
- Zero-wait slave (PREADY high in cycle 1) → HREADY_x and HRDATA_x valid in cycle 2.
- Minimum latency is 2 cycles. Maximum throughput is one transfer per 2 cycles.
- Each slave wait cycle adds 1 cycle.
- Timeout: HREADY_x and bus_err are high in cycle TIMEOUT+1 after PSEL rose.
- stall_x is combinational and low in the HREADY_x cycle.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - On a tie, the master not granted last wins.
  - The last-grant register updates on every grant; after reset it holds master 2, so master 1 wins the first tie.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, master 2 always wins a tie, and the last-grant register is unused.

## Test plan
- **Single read:** M1 read of 0x1000 with PREADY tied high and PRDATA=0xDEADBEEF → PSEL in cycle 1, HREADY_1=1 in cycle 2, HRDATA_1=0xDEADBEEF, stall_1 high for cycles 0–1.
- **Simultaneous requests:** M1 read 0x0 and M2 write 0x80/0x55.
  - Fixed priority: M2 served first (HREADY_2 in cycle 2), then M1 granted in cycle 3 (HREADY_1 in cycle 4).
  - With ARB_ROUND_ROBIN_EN: M1 first.
  - For the M2 write, HRDATA_2 stays 0.
- **Wait states:** PREADY held low for 3 cycles after PSEL → HREADY_1 in cycle 5, with PADDR stable throughout.
- **Timeout:** TIMEOUT=4 and PREADY never asserted → HREADY_2=1, bus_err=1, HRDATA_2=0 in cycle 5; next request is granted normally.
- **Reset mid-BUSY:** reset high for 1 cycle during wait → next cycle PSEL=0, no HREADY pulse, all outputs 0; a subsequent M1 request completes in 2 cycles.
- **Back-to-back:** M1 holds HTRANS_1 high across HREADY_1 with PREADY=1 → a completion every 2 cycles for 4 transfers.
